// File: rtl/nrs_sched_pkg.sv
// Shared definitions for the NRS read-port scheduler: FSM states, requester IDs
// and the default buffer depth.
package nrs_sched_pkg;

    localparam int DEFAULT_DEPTH = 16;

    localparam int REQ_EST  = 0;
    localparam int REQ_FINE = 1;

    typedef enum logic [2:0] {
        WAIT_RDY,
        ARB,
        BURST,
        ACK,
        WAIT_LOW
    } state_t;

endpackage

// File: rtl/nrs_rr_arb2.sv
// Two-way round-robin arbiter. ptr=0 favours requester 0 (EST); after every
// advanced grant the pointer moves to the side that did not win.
module nrs_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req[0] && req[1]) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // A win by side 0 favours side 1 next time, and vice versa
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/nrs_read_scheduler.sv
// Shares the NRS register read port between EST and FINE: arbitrates burst
// requests, issues wrapping read addresses, routes data and releases buffers.
module nrs_read_scheduler
    import nrs_sched_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LINES = $clog2(DEPTH),
    parameter int LEN_W = LINES + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_ready,
    input  logic             req_est,
    input  logic [LINES-1:0] base_est,
    input  logic [LEN_W-1:0] len_est,
    input  logic             est_release,
    input  logic             req_fine,
    input  logic [LINES-1:0] base_fine,
    input  logic [LEN_W-1:0] len_fine,
    input  logic             nrs_r,
    input  logic             nrs_i,
    output logic [LINES-1:0] rd_addr,
    output logic             gnt_est,
    output logic             gnt_fine,
    output logic             rej_est,
    output logic             rej_fine,
    output logic             dout_r,
    output logic             dout_i,
    output logic             vld_est,
    output logic             vld_fine,
    output logic             dout_last,
    output logic             est_ack,
    output logic             err
);

    state_t           state;
    logic [LINES-1:0] addr_ptr;
    logic [LEN_W-1:0] remaining;
    logic             side;
    logic             rd_act;
    logic             rd_last;
    logic             pending;

    logic             bad_est;
    logic             bad_fine;
    logic             eval;
    logic [1:0]       arb_req;
    logic [1:0]       arb_gnt;

    // A request still high in the cycle its reject is shown is the same request,
    // so it is masked to avoid rejecting it twice.
    always_comb begin
        bad_est  = req_est && !rej_est &&
                   ((len_est == '0) || (len_est > LEN_W'(DEPTH)));
        bad_fine = req_fine && !rej_fine &&
                   ((len_fine == '0) || (len_fine > LEN_W'(DEPTH)));
        eval     = (state == ARB) && gen_ready && !(est_release || pending);
        arb_req  = 2'b00;
        if (eval) begin
            arb_req[REQ_EST]  = req_est && !rej_est && !bad_est;
            arb_req[REQ_FINE] = req_fine && !rej_fine && !bad_fine;
        end
    end

    nrs_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (eval),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_RDY;
            addr_ptr  <= '0;
            remaining <= '0;
            side      <= 1'b0;
            rd_act    <= 1'b0;
            rd_last   <= 1'b0;
            pending   <= 1'b0;
            rd_addr   <= '0;
            gnt_est   <= 1'b0;
            gnt_fine  <= 1'b0;
            rej_est   <= 1'b0;
            rej_fine  <= 1'b0;
            dout_r    <= 1'b0;
            dout_i    <= 1'b0;
            vld_est   <= 1'b0;
            vld_fine  <= 1'b0;
            dout_last <= 1'b0;
            est_ack   <= 1'b0;
            err       <= 1'b0;
        end else begin
            gnt_est   <= 1'b0;
            gnt_fine  <= 1'b0;
            rej_est   <= 1'b0;
            rej_fine  <= 1'b0;
            vld_est   <= 1'b0;
            vld_fine  <= 1'b0;
            dout_last <= 1'b0;
            est_ack   <= 1'b0;
            case (state)
                WAIT_RDY: begin
                    if (gen_ready) state <= ARB;
                end
                ARB: begin
                    if (!gen_ready) begin
                        state   <= WAIT_RDY;
                        pending <= 1'b0;
                    end else if (est_release || pending) begin
                        est_ack <= 1'b1;
                        pending <= 1'b0;
                        state   <= ACK;
                    end else begin
                        rej_est  <= bad_est;
                        rej_fine <= bad_fine;
                        if (arb_gnt != 2'b00) begin
                            gnt_est   <= arb_gnt[REQ_EST];
                            gnt_fine  <= arb_gnt[REQ_FINE];
                            side      <= arb_gnt[REQ_FINE];
                            addr_ptr  <= arb_gnt[REQ_FINE] ? base_fine : base_est;
                            remaining <= arb_gnt[REQ_FINE] ? len_fine : len_est;
                            state     <= BURST;
                        end
                    end
                end
                BURST: begin
                    // Losing the buffer kills the burst, including the beat in flight
                    if (!gen_ready) begin
                        err     <= 1'b1;
                        rd_act  <= 1'b0;
                        pending <= 1'b0;
                        state   <= WAIT_RDY;
                    end else begin
                        if (est_release) pending <= 1'b1;
                        if (rd_act) begin
                            dout_r    <= nrs_r;
                            dout_i    <= nrs_i;
                            vld_est   <= (side == 1'(REQ_EST));
                            vld_fine  <= (side == 1'(REQ_FINE));
                            dout_last <= rd_last;
                        end
                        if (remaining != '0) begin
                            rd_addr   <= addr_ptr;
                            addr_ptr  <= addr_ptr + LINES'(1);
                            remaining <= remaining - LEN_W'(1);
                            rd_act    <= 1'b1;
                            rd_last   <= (remaining == LEN_W'(1));
                        end else begin
                            rd_act <= 1'b0;
                            state  <= ARB;
                        end
                    end
                end
                ACK: begin
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!gen_ready) state <= WAIT_RDY;
                end
                default: begin
                    state <= WAIT_RDY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrs_read_scheduler.sv
// Directed bench for nrs_read_scheduler: bursts, round-robin order, wrap,
// rejects, buffer release, gen_ready abort and asynchronous reset.
module tb_nrs_read_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       gen_ready;
    logic       req_est;
    logic [3:0] base_est;
    logic [4:0] len_est;
    logic       est_release;
    logic       req_fine;
    logic [3:0] base_fine;
    logic [4:0] len_fine;
    logic       nrs_r;
    logic       nrs_i;
    logic [3:0] rd_addr;
    logic       gnt_est;
    logic       gnt_fine;
    logic       rej_est;
    logic       rej_fine;
    logic       dout_r;
    logic       dout_i;
    logic       vld_est;
    logic       vld_fine;
    logic       dout_last;
    logic       est_ack;
    logic       err;

    logic [15:0] pat_r = 16'hA5C3;
    logic [15:0] pat_i = 16'h3C96;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // NRS register model: data follows the registered read address
    assign nrs_r = pat_r[rd_addr];
    assign nrs_i = pat_i[rd_addr];

    nrs_read_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .gen_ready   (gen_ready),
        .req_est     (req_est),
        .base_est    (base_est),
        .len_est     (len_est),
        .est_release (est_release),
        .req_fine    (req_fine),
        .base_fine   (base_fine),
        .len_fine    (len_fine),
        .nrs_r       (nrs_r),
        .nrs_i       (nrs_i),
        .rd_addr     (rd_addr),
        .gnt_est     (gnt_est),
        .gnt_fine    (gnt_fine),
        .rej_est     (rej_est),
        .rej_fine    (rej_fine),
        .dout_r      (dout_r),
        .dout_i      (dout_i),
        .vld_est     (vld_est),
        .vld_fine    (vld_fine),
        .dout_last   (dout_last),
        .est_ack     (est_ack),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_gnt"}, {gnt_est, gnt_fine}, 0);
        check({tag, "_rej"}, {rej_est, rej_fine}, 0);
        check({tag, "_dout"}, {dout_r, dout_i}, 0);
        check({tag, "_vld"}, {vld_est, vld_fine}, 0);
        check({tag, "_last"}, dout_last, 0);
        check({tag, "_ack"}, est_ack, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic await_grant(input logic side);
        int n    = 0;
        bit seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt_est || gnt_fine) seen = 1;
        end
        check("gnt_seen", seen, 1);
        if (seen) begin
            check("gnt_est", gnt_est, !side);
            check("gnt_fine", gnt_fine, side);
            if (gnt_est) req_est = 1'b0;
            if (gnt_fine) req_fine = 1'b0;
        end
    endtask

    // Called at the negedge of the grant cycle G; walks cycles G+1 .. G+len+1
    task automatic burst_check(input logic side, input int base, input int len,
                               input int rel_at, input int abort_at);
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            check("ack_idle", est_ack, 0);
            if (abort_at != 0 && c > abort_at) begin
                check("abort_vld", {vld_est, vld_fine}, 0);
                check("abort_last", dout_last, 0);
                check("abort_err", err, 1);
            end else begin
                if (c <= len) check("rd_addr", rd_addr, (base + c - 1) % 16);
                if (c >= 2) begin
                    int b = c - 2;
                    int a = (base + b) % 16;
                    check("vld_est", vld_est, !side);
                    check("vld_fine", vld_fine, side);
                    check("dout_r", dout_r, pat_r[a]);
                    check("dout_i", dout_i, pat_i[a]);
                    check("dout_last", dout_last, (b == len - 1));
                end else begin
                    check("vld_pre", {vld_est, vld_fine}, 0);
                end
            end
            est_release = (c == rel_at);
            if (abort_at != 0 && c == abort_at) gen_ready = 1'b0;
        end
        est_release = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        gen_ready   = 1'b0;
        req_est     = 1'b0;
        base_est    = '0;
        len_est     = '0;
        est_release = 1'b0;
        req_fine    = 1'b0;
        base_fine   = '0;
        len_fine    = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Full-buffer EST burst; pointer then favours FINE
        gen_ready = 1'b1;
        base_est  = 4'd0;
        len_est   = 5'd16;
        req_est   = 1'b1;
        await_grant(1'b0);
        burst_check(1'b0, 0, 16, 0, 0);

        // Bad lengths are rejected without touching the pointer
        len_est = 5'd0;
        req_est = 1'b1;
        @(negedge clk);
        check("rej_len0", rej_est, 1);
        check("rej_len0_gnt", gnt_est, 0);
        req_est = 1'b0;
        @(negedge clk);
        check("rej_len0_pulse", rej_est, 0);
        check("rej_len0_vld", {vld_est, vld_fine}, 0);
        len_est = 5'd17;
        req_est = 1'b1;
        @(negedge clk);
        check("rej_len17", rej_est, 1);
        check("rej_len17_gnt", gnt_est, 0);
        req_est = 1'b0;
        @(negedge clk);
        check("rej_len17_pulse", rej_est, 0);
        check("rej_len17_vld", {vld_est, vld_fine}, 0);

        // Contention twice: FINE, EST, FINE, EST
        base_est  = 4'd2;
        len_est   = 5'd4;
        base_fine = 4'd8;
        len_fine  = 5'd4;
        req_est   = 1'b1;
        req_fine  = 1'b1;
        await_grant(1'b1);
        burst_check(1'b1, 8, 4, 0, 0);
        await_grant(1'b0);
        burst_check(1'b0, 2, 4, 0, 0);
        base_est  = 4'd15;
        base_fine = 4'd11;
        req_est   = 1'b1;
        req_fine  = 1'b1;
        await_grant(1'b1);
        burst_check(1'b1, 11, 4, 0, 0);
        await_grant(1'b0);
        burst_check(1'b0, 15, 4, 0, 0);

        // FINE burst wrapping 14,15,0,1; address then holds while idle
        base_fine = 4'd14;
        len_fine  = 5'd4;
        req_fine  = 1'b1;
        await_grant(1'b1);
        burst_check(1'b1, 14, 4, 0, 0);
        repeat (3) @(negedge clk);
        check("rd_addr_hold", rd_addr, 1);

        // Release during a burst: ack right after the last beat, then lockout
        base_est = 4'd5;
        len_est  = 5'd8;
        req_est  = 1'b1;
        await_grant(1'b0);
        burst_check(1'b0, 5, 8, 3, 0);
        @(negedge clk);
        check("est_ack", est_ack, 1);
        base_fine = 4'd0;
        len_fine  = 5'd2;
        req_fine  = 1'b1;
        @(negedge clk);
        check("est_ack_pulse", est_ack, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gnt_blocked_low", {gnt_est, gnt_fine}, 0);
        end
        gen_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("gnt_blocked_rdy", {gnt_est, gnt_fine}, 0);
        end
        gen_ready = 1'b1;
        await_grant(1'b1);
        burst_check(1'b1, 0, 2, 0, 0);

        // gen_ready falls before beat 3: burst aborts and err sticks
        base_est = 4'd0;
        len_est  = 5'd8;
        req_est  = 1'b1;
        await_grant(1'b0);
        burst_check(1'b0, 0, 8, 0, 3);
        gen_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);

        // Asynchronous reset in the middle of a burst
        base_est = 4'd4;
        len_est  = 5'd8;
        req_est  = 1'b1;
        await_grant(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_vld", {vld_est, vld_fine, dout_last}, 0);
        end

        // Normal service resumes after reset
        base_est = 4'd3;
        len_est  = 5'd2;
        req_est  = 1'b1;
        await_grant(1'b0);
        burst_check(1'b0, 3, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
